// File: rtl/seq_alu_param_if.sv
// Request/response bundle for seq_alu_param: operand stream in, result and status out.
// The master drives requests and words; the slave (the ALU) returns status and results.
interface seq_alu_param_if #(
   parameter int W = 8
);
   logic           i_start;
   logic [1:0]     i_op;
   logic [W-1:0]   i_inbus;
   logic           o_ready;
   logic           o_final;
   logic [2*W-1:0] o_outbus;
   logic           o_ovf;
   logic           o_dbz;
   logic [2:0]     o_state;

   modport master (
      output i_start, i_op, i_inbus,
      input  o_ready, o_final, o_outbus, o_ovf, o_dbz, o_state
   );

   modport slave (
      input  i_start, i_op, i_inbus,
      output o_ready, o_final, o_outbus, o_ovf, o_dbz, o_state
   );
endinterface

// File: rtl/seq_alu_param.sv
// Multi-cycle W-bit ALU: add, sub, Booth signed multiply, restoring unsigned divide.
// Operands arrive word-by-word on i_inbus; the result lands on o_outbus with a one-cycle o_final.
module seq_alu_param #(
   parameter int W = 8
) (
   input logic            clk,
   input logic            rst,
   seq_alu_param_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD1 = 3'd1,
      LOAD2 = 3'd2,
      EXEC  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   state_t         r_state;
   state_t         w_state_next;
   logic [1:0]     r_op;
   logic [W-1:0]   r_w0;
   logic [W-1:0]   r_w1;
   logic [W-1:0]   r_w2;
   logic [W:0]     r_a;
   logic [W-1:0]   r_q;
   logic           r_qm1;
   logic [5:0]     r_cnt;
   logic [2*W-1:0] r_out;
   logic           r_ovf;
   logic           r_dbz;

   logic           w_last;
   logic [W-1:0]   w_sum;
   logic [W-1:0]   w_diff;
   logic           w_add_ovf;
   logic           w_sub_ovf;
   logic [W:0]     w_m_ext;
   logic [W:0]     w_booth_sum;
   logic [W:0]     w_booth_a;
   logic [W-1:0]   w_booth_q;
   logic [W:0]     w_div_shift;
   logic [W:0]     w_div_trial;
   logic           w_div_ge;
   logic [W-1:0]   w_div_r;
   logic [W-1:0]   w_div_q;
   logic           w_div_bad;

   assign w_last = (r_cnt == 6'(W - 1));

   assign w_sum     = r_w0 + r_w1;
   assign w_diff    = r_w1 - r_w0;
   assign w_add_ovf = (r_w0[W-1] == r_w1[W-1]) && (w_sum[W-1] != r_w0[W-1]);
   assign w_sub_ovf = (r_w1[W-1] != r_w0[W-1]) && (w_diff[W-1] != r_w1[W-1]);

   // Booth step on {A,Q,q-1}; A carries an extra sign bit so -2^(W-1) squared fits.
   assign w_m_ext = {r_w0[W-1], r_w0};

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_booth_sum = r_a;
      case ({r_q[0], r_qm1})
         2'b01:   w_booth_sum = r_a + w_m_ext;
         2'b10:   w_booth_sum = r_a - w_m_ext;
         default: w_booth_sum = r_a;
      endcase
   end

   assign w_booth_a = {w_booth_sum[W], w_booth_sum[W:1]};
   assign w_booth_q = {w_booth_sum[0], r_q[W-1:1]};

   // Restoring step: partial remainder is always below the divisor, so W+1 bits hold the trial sign.
   assign w_div_shift = {r_a[W-1:0], r_q[W-1]};
   assign w_div_trial = w_div_shift - {1'b0, r_w2};
   assign w_div_ge    = ~w_div_trial[W];
   assign w_div_r     = w_div_ge ? w_div_trial[W-1:0] : w_div_shift[W-1:0];
   assign w_div_q     = {r_q[W-2:0], w_div_ge};

   assign w_div_bad = (bus.i_inbus == '0) || (r_w0 >= bus.i_inbus);

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (bus.i_start) w_state_next = LOAD1;
         LOAD1:   w_state_next = (r_op == OP_DIV) ? LOAD2 : EXEC;
         LOAD2:   w_state_next = w_div_bad ? DONE : EXEC;
         EXEC:    if ((r_op == OP_ADD) || (r_op == OP_SUB) || w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op  <= '0;
         r_w0  <= '0;
         r_w1  <= '0;
         r_w2  <= '0;
         r_a   <= '0;
         r_q   <= '0;
         r_qm1 <= 1'b0;
         r_cnt <= '0;
         r_out <= '0;
         r_ovf <= 1'b0;
         r_dbz <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.i_start) begin
                  r_op  <= bus.i_op;
                  r_w0  <= bus.i_inbus;
                  r_ovf <= 1'b0;
                  r_dbz <= 1'b0;
               end
            end
            LOAD1: begin
               r_w1  <= bus.i_inbus;
               r_a   <= '0;
               r_q   <= bus.i_inbus;
               r_qm1 <= 1'b0;
               r_cnt <= '0;
            end
            LOAD2: begin
               r_w2  <= bus.i_inbus;
               r_a   <= {1'b0, r_w0};
               r_q   <= r_w1;
               r_cnt <= '0;
               if (bus.i_inbus == '0) begin
                  r_dbz <= 1'b1;
                  r_out <= '1;
               end else if (r_w0 >= bus.i_inbus) begin
                  r_ovf <= 1'b1;
                  r_out <= '1;
               end
            end
            EXEC: begin
               unique case (r_op)
                  OP_ADD: begin
                     r_out <= {w_sum, {W{1'b0}}};
                     r_ovf <= w_add_ovf;
                  end
                  OP_SUB: begin
                     r_out <= {w_diff, {W{1'b0}}};
                     r_ovf <= w_sub_ovf;
                  end
                  OP_MUL: begin
                     r_a   <= w_booth_a;
                     r_q   <= w_booth_q;
                     r_qm1 <= r_q[0];
                     r_cnt <= r_cnt + 6'd1;
                     if (w_last) r_out <= {w_booth_a[W-1:0], w_booth_q};
                  end
                  default: begin
                     r_a   <= {1'b0, w_div_r};
                     r_q   <= w_div_q;
                     r_cnt <= r_cnt + 6'd1;
                     if (w_last) r_out <= {w_div_r, w_div_q};
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   assign bus.o_ready  = (r_state == IDLE);
   assign bus.o_final  = (r_state == DONE);
   assign bus.o_outbus = r_out;
   assign bus.o_ovf    = r_ovf;
   assign bus.o_dbz    = r_dbz;
   assign bus.o_state  = r_state;

endmodule

// File: tb/tb_seq_alu_param.sv
// Directed bench for seq_alu_param at W=8 and W=16: results, flags, completion cycle,
// output hold through IDLE, reset abort and ignored start during EXEC.
module tb_seq_alu_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst8;
   logic rst16;

   seq_alu_param_if #(.W(8))  bus8 ();
   seq_alu_param_if #(.W(16)) bus16 ();

   seq_alu_param #(.W(8))  dut8  (.clk(clk), .rst(rst8),  .bus(bus8));
   seq_alu_param #(.W(16)) dut16 (.clk(clk), .rst(rst16), .bus(bus16));

   int n_total = 0;
   int n_pass  = 0;
   logic [63:0] last8  = '0;
   logic [63:0] last16 = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_in(input int sel, input logic s, input logic [1:0] o, input logic [31:0] d);
      if (sel == 8) begin
         bus8.i_start = s;
         bus8.i_op    = o;
         bus8.i_inbus = d[7:0];
      end else begin
         bus16.i_start = s;
         bus16.i_op    = o;
         bus16.i_inbus = d[15:0];
      end
   endtask

   task automatic sample(input int sel, output logic [63:0] out, output logic fin, output logic rdy,
                         output logic ovf, output logic dbz, output logic [2:0] st);
      if (sel == 8) begin
         out = 64'(bus8.o_outbus);
         fin = bus8.o_final;
         rdy = bus8.o_ready;
         ovf = bus8.o_ovf;
         dbz = bus8.o_dbz;
         st  = bus8.o_state;
      end else begin
         out = 64'(bus16.o_outbus);
         fin = bus16.o_final;
         rdy = bus16.o_ready;
         ovf = bus16.o_ovf;
         dbz = bus16.o_dbz;
         st  = bus16.o_state;
      end
   endtask

   // One transaction: checks idle state and held output, then result, flags and final cycle.
   task automatic op_run(input string tag, input int sel, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [63:0] exp_out, input logic exp_ovf, input logic exp_dbz,
                         input int exp_cyc, input bit poke);
      logic [63:0] out;
      logic fin, rdy, ovf, dbz;
      logic [2:0] st;
      int cyc;
      @(negedge clk);
      sample(sel, out, fin, rdy, ovf, dbz, st);
      check({tag, "/ready"}, 64'(rdy), 64'd1);
      check({tag, "/held"}, out, (sel == 8) ? last8 : last16);
      set_in(sel, 1'b1, o, a);
      @(posedge clk);
      @(negedge clk);
      set_in(sel, 1'b0, o, b);
      @(posedge clk);
      @(negedge clk);
      set_in(sel, 1'b0, o, c);
      cyc = 2;
      sample(sel, out, fin, rdy, ovf, dbz, st);
      while (!fin && cyc < 100) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (poke && cyc == 5) set_in(sel, 1'b1, 2'b00, 32'h5A5A_5A5A);
         else if (poke && cyc == 6) set_in(sel, 1'b0, o, c);
         sample(sel, out, fin, rdy, ovf, dbz, st);
      end
      check({tag, "/final_cycle"}, fin ? 64'(cyc) : 64'd0, 64'(exp_cyc));
      check({tag, "/outbus"}, out, exp_out);
      check({tag, "/ovf"}, 64'(ovf), 64'(exp_ovf));
      check({tag, "/dbz"}, 64'(dbz), 64'(exp_dbz));
      if (sel == 8) last8 = exp_out;
      else          last16 = exp_out;
   endtask

   initial begin
      logic [63:0] out;
      logic fin, rdy, ovf, dbz, fin_seen;
      logic [2:0] st;

      rst8  = 1'b1;
      rst16 = 1'b1;
      set_in(8, 1'b0, 2'b00, 32'd0);
      set_in(16, 1'b0, 2'b00, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst8  = 1'b0;
      rst16 = 1'b0;
      sample(8, out, fin, rdy, ovf, dbz, st);
      check("reset/state", 64'(st), 64'd0);
      check("reset/ready", 64'(rdy), 64'd1);
      check("reset/final", 64'(fin), 64'd0);
      check("reset/outbus", out, 64'd0);
      check("reset/ovf", 64'(ovf), 64'd0);
      check("reset/dbz", 64'(dbz), 64'd0);

      // W=8: add/sub with and without signed overflow
      op_run("add60_55",   8, 2'b00, 60,    55,    0, 64'h7300, 1'b0, 1'b0, 3, 1'b0);
      op_run("add100_100", 8, 2'b00, 100,   100,   0, 64'hC800, 1'b1, 1'b0, 3, 1'b0);
      op_run("sub120_60",  8, 2'b01, 60,    120,   0, 64'h3C00, 1'b0, 1'b0, 3, 1'b0);
      op_run("sub_m15_25", 8, 2'b01, 25,    8'hF1, 0, 64'hD800, 1'b0, 1'b0, 3, 1'b0);
      op_run("sub_ovf",    8, 2'b01, 1,     8'h80, 0, 64'h7F00, 1'b1, 1'b0, 3, 1'b0);

      // W=8: Booth multiply including the most-negative corner
      op_run("mul50_m12",  8, 2'b10, 50,    8'hF4, 0, 64'hFDA8, 1'b0, 1'b0, 10, 1'b0);
      op_run("mul_m128sq", 8, 2'b10, 8'h80, 8'h80, 0, 64'h4000, 1'b0, 1'b0, 10, 1'b0);
      op_run("mul60_60",   8, 2'b10, 60,    60,    0, 64'h0E10, 1'b0, 1'b0, 10, 1'b0);
      op_run("mul127_m128",8, 2'b10, 127,   8'h80, 0, 64'hC080, 1'b0, 1'b0, 10, 1'b0);

      // W=8: divide, normal, largest quotient, zero divisor, overflow at and above boundary
      op_run("div1000_12", 8, 2'b11, 8'h03, 8'hE8, 12,   64'h0453, 1'b0, 1'b0, 11, 1'b0);
      op_run("div_qmax",   8, 2'b11, 8'h0B, 8'hFF, 12,   64'h0BFF, 1'b0, 1'b0, 11, 1'b0);
      op_run("div_zero",   8, 2'b11, 8'h03, 8'hE8, 0,    64'hFFFF, 1'b0, 1'b1, 3,  1'b0);
      op_run("div_ovf",    8, 2'b11, 8'h10, 8'h00, 8'h08, 64'hFFFF, 1'b1, 1'b0, 3, 1'b0);
      op_run("div_ovf_eq", 8, 2'b11, 8'h05, 8'h00, 8'h05, 64'hFFFF, 1'b1, 1'b0, 3, 1'b0);

      // W=8: reset during multiply EXEC aborts without a final strobe
      @(negedge clk);
      set_in(8, 1'b1, 2'b10, 50);
      @(posedge clk);
      @(negedge clk);
      set_in(8, 1'b0, 2'b10, 8'hF4);
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      sample(8, out, fin, rdy, ovf, dbz, st);
      check("abort/in_exec", 64'(st), 64'd3);
      rst8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst8 = 1'b0;
      sample(8, out, fin, rdy, ovf, dbz, st);
      check("abort/state", 64'(st), 64'd0);
      check("abort/ready", 64'(rdy), 64'd1);
      check("abort/outbus", out, 64'd0);
      fin_seen = fin;
      repeat (10) begin
         @(negedge clk);
         sample(8, out, fin, rdy, ovf, dbz, st);
         fin_seen = fin_seen | fin;
      end
      check("abort/no_final", 64'(fin_seen), 64'd0);
      last8 = '0;
      op_run("add1_2", 8, 2'b00, 1, 2, 0, 64'h0300, 1'b0, 1'b0, 3, 1'b0);

      // W=16 regression, with a start pulse during EXEC of the multiply
      op_run("w16_mul",    16, 2'b10, 30000,   16'hFFFD, 0,        64'hFFFE_A070, 1'b0, 1'b0, 18, 1'b1);
      op_run("w16_div",    16, 2'b11, 16'h0001, 16'h0000, 16'h0100, 64'h0000_0100, 1'b0, 1'b0, 19, 1'b0);
      op_run("w16_add",    16, 2'b00, 16'h7FFF, 16'h0001, 0,        64'h8000_0000, 1'b1, 1'b0, 3,  1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
